// File: rtl/vec_alu_seq_if.sv
// Bundle of command, register-file, ALU, writeback and status signals around vec_alu_seq.
// master = decoder/ALU/register-file side, slave = the sequencer.
interface vec_alu_seq_if #(
    parameter int VLEN  = 8,
    parameter int NVREG = 8
);
    localparam int EW = $clog2(VLEN);
    localparam int RW = $clog2(NVREG);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic              cmd_sign;
    logic [4:0]        cmd_shamt;
    logic [RW-1:0]     cmd_va;
    logic [RW-1:0]     cmd_vb;
    logic [RW-1:0]     cmd_vd;
    logic [EW:0]       cmd_len;

    logic [RW+EW-1:0]  rd_a_addr;
    logic [RW+EW-1:0]  rd_b_addr;
    logic [31:0]       rd_a_data;
    logic [31:0]       rd_b_data;

    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [3:0]        alu_op;
    logic              alu_sign;
    logic [4:0]        alu_shamt;
    logic [31:0]       alu_res;
    logic              alu_zero;
    logic              alu_overflow;
    logic              alu_cout;

    logic              wr_en;
    logic [RW+EW-1:0]  wr_addr;
    logic [31:0]       wr_data;

    logic              done;
    logic              st_overflow;
    logic              st_cout;
    logic              st_all_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_sign, cmd_shamt, cmd_va, cmd_vb, cmd_vd, cmd_len,
        output rd_a_data, rd_b_data, alu_res, alu_zero, alu_overflow, alu_cout,
        input  cmd_ready, rd_a_addr, rd_b_addr, alu_a, alu_b, alu_op, alu_sign, alu_shamt,
        input  wr_en, wr_addr, wr_data, done, st_overflow, st_cout, st_all_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sign, cmd_shamt, cmd_va, cmd_vb, cmd_vd, cmd_len,
        input  rd_a_data, rd_b_data, alu_res, alu_zero, alu_overflow, alu_cout,
        output cmd_ready, rd_a_addr, rd_b_addr, alu_a, alu_b, alu_op, alu_sign, alu_shamt,
        output wr_en, wr_addr, wr_data, done, st_overflow, st_cout, st_all_zero
    );
endinterface

// File: rtl/vec_alu_seq.sv
// Element-by-element vector command sequencer driving a shared scalar ALU and vector register file.
// Optional status accumulation is built when VSEQ_FLAG_ACCUM_EN is defined.
module vec_alu_seq #(
    parameter int VLEN  = 8,
    parameter int NVREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    vec_alu_seq_if.slave  bus
);
    localparam int EW = $clog2(VLEN);
    localparam int RW = $clog2(NVREG);
    localparam logic [EW:0]   VLEN_W   = (EW+1)'(VLEN);
    localparam logic [EW:0]   LEN_ONE  = (EW+1)'(1);
    localparam logic [EW:0]   LEN_ZERO = (EW+1)'(0);
    localparam logic [EW-1:0] IDX_ONE  = EW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        op_r;
    logic              sign_r;
    logic [4:0]        shamt_r;
    logic [RW-1:0]     va_r;
    logic [RW-1:0]     vb_r;
    logic [RW-1:0]     vd_r;
    logic [EW:0]       len_r;
    logic [EW:0]       len_clamp_s;
    logic [EW-1:0]     idx_r;
    logic              cmd_ready_r;
    logic              done_r;
    logic              wr_en_r;
    logic [RW+EW-1:0]  wr_addr_r;
    logic [31:0]       wr_data_r;
    logic              accept_s;
    logic              last_elem_s;

    assign accept_s    = bus.cmd_valid & cmd_ready_r;
    assign last_elem_s = (state_r == RUN) && ({1'b0, idx_r} == (len_r - LEN_ONE));

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.done      = done_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;

    // Over-long requests saturate at the register length
    always_comb begin
        len_clamp_s = bus.cmd_len;
        if (bus.cmd_len > VLEN_W) begin
            len_clamp_s = VLEN_W;
        end else begin
            len_clamp_s = bus.cmd_len;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = (len_clamp_s == LEN_ZERO) ? LAST : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_elem_s) begin
                    state_s = LAST;
                end else begin
                    state_s = RUN;
                end
            end
            LAST:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Read ports and ALU controls are live only while issuing elements
    always_comb begin
        bus.rd_a_addr = {(RW+EW){1'b0}};
        bus.rd_b_addr = {(RW+EW){1'b0}};
        bus.alu_a     = 32'd0;
        bus.alu_b     = 32'd0;
        bus.alu_op    = 4'd0;
        bus.alu_sign  = 1'b0;
        bus.alu_shamt = 5'd0;
        if (state_r == RUN) begin
            bus.rd_a_addr = {va_r, idx_r};
            bus.rd_b_addr = {vb_r, idx_r};
            bus.alu_a     = bus.rd_a_data;
            bus.alu_b     = bus.rd_b_data;
            bus.alu_op    = op_r;
            bus.alu_sign  = sign_r;
            bus.alu_shamt = shamt_r;
        end else begin
            bus.alu_op    = 4'd0;
        end
    end

    // State register plus registered handshake and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= (state_s == IDLE);
            done_r      <= (state_s == LAST);
        end
    end

    // Command latch and element counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r    <= 4'd0;
            sign_r  <= 1'b0;
            shamt_r <= 5'd0;
            va_r    <= {RW{1'b0}};
            vb_r    <= {RW{1'b0}};
            vd_r    <= {RW{1'b0}};
            len_r   <= {(EW+1){1'b0}};
            idx_r   <= {EW{1'b0}};
        end else if (accept_s) begin
            op_r    <= bus.cmd_op;
            sign_r  <= bus.cmd_sign;
            shamt_r <= bus.cmd_shamt;
            va_r    <= bus.cmd_va;
            vb_r    <= bus.cmd_vb;
            vd_r    <= bus.cmd_vd;
            len_r   <= len_clamp_s;
            idx_r   <= {EW{1'b0}};
        end else if (state_r == RUN) begin
            idx_r   <= idx_r + IDX_ONE;
        end
    end

    // Writeback stage: the element issued this cycle is written next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {(RW+EW){1'b0}};
            wr_data_r <= 32'd0;
        end else begin
            wr_en_r <= (state_r == RUN);
            if (state_r == RUN) begin
                wr_addr_r <= {vd_r, idx_r};
                wr_data_r <= bus.alu_res;
            end
        end
    end

`ifdef VSEQ_FLAG_ACCUM_EN
    logic acc_ov_r;
    logic acc_co_r;
    logic acc_z_r;
    logic st_ov_r;
    logic st_co_r;
    logic st_z_r;

    assign bus.st_overflow = st_ov_r;
    assign bus.st_cout     = st_co_r;
    assign bus.st_all_zero = st_z_r;

    // Fold per-element flags; publish the fold (including the last element) on entry to LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_ov_r <= 1'b0;
            acc_co_r <= 1'b0;
            acc_z_r  <= 1'b1;
            st_ov_r  <= 1'b0;
            st_co_r  <= 1'b0;
            st_z_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                acc_ov_r <= 1'b0;
                acc_co_r <= 1'b0;
                acc_z_r  <= 1'b1;
            end else if (state_r == RUN) begin
                acc_ov_r <= acc_ov_r | bus.alu_overflow;
                acc_co_r <= acc_co_r | bus.alu_cout;
                acc_z_r  <= acc_z_r & bus.alu_zero;
            end
            if (last_elem_s) begin
                st_ov_r <= acc_ov_r | bus.alu_overflow;
                st_co_r <= acc_co_r | bus.alu_cout;
                st_z_r  <= acc_z_r & bus.alu_zero;
            end else if (accept_s && (len_clamp_s == LEN_ZERO)) begin
                st_ov_r <= 1'b0;
                st_co_r <= 1'b0;
                st_z_r  <= 1'b1;
            end
        end
    end
`else
    assign bus.st_overflow = 1'b0;
    assign bus.st_cout     = 1'b0;
    assign bus.st_all_zero = 1'b0;
`endif

endmodule

// File: tb/tb_vec_alu_seq.sv
// Randomised self-checking bench for vec_alu_seq with a per-cycle expectation timeline.
module tb_vec_alu_seq;
    localparam int VLEN  = 8;
    localparam int NVREG = 8;
    localparam int EW    = 3;
    localparam int RW    = 3;
    localparam int NE    = VLEN * NVREG;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_alu_seq_if #(.VLEN(VLEN), .NVREG(NVREG)) bus ();
    vec_alu_seq #(.VLEN(VLEN), .NVREG(NVREG)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last_done = -1;
    bit chk_en  = 1'b0;
    logic [2:0] cur_st = 3'b000;

    logic [31:0] rf       [NE];
    logic [31:0] model_rf [NE];
    logic             pl_en   = 1'b0;
    logic [RW+EW-1:0] pl_addr = '0;
    logic [31:0]      pl_data = 32'd0;

    bit               exp_we   [int];
    logic [RW+EW-1:0] exp_wa   [int];
    logic [31:0]      exp_wd   [int];
    bit               exp_done [int];
    bit               busy     [int];
    logic [RW+EW-1:0] exp_ra   [int];
    logic [31:0]      exp_aa   [int];
    logic [2:0]       exp_st   [int];

    // Scalar ALU: {zero, overflow, carry, result}
    function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic sg, input logic [4:0] sh,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic ov, co;
        ov = 1'b0; co = 1'b0; s = 33'd0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
                        ov = sg & (a[31] == b[31]) & (r[31] != a[31]); end
            4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
                        ov = sg & (a[31] != b[31]) & (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = sg ? 32'($signed(a) >>> sh) : (a >> sh);
            4'd7: r = {31'd0, sg ? ($signed(a) < $signed(b)) : (a < b)};
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), ov, co, r};
    endfunction

    assign bus.rd_a_data = rf[bus.rd_a_addr];
    assign bus.rd_b_data = rf[bus.rd_b_addr];
    always_comb {bus.alu_zero, bus.alu_overflow, bus.alu_cout, bus.alu_res} =
        alu_fn(bus.alu_op, bus.alu_sign, bus.alu_shamt, bus.alu_a, bus.alu_b);

    always @(posedge clk) begin
        if (bus.wr_en) rf[bus.wr_addr] <= bus.wr_data;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    endtask

    // Per-cycle comparison against the expectation timeline
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (exp_st.exists(cyc)) cur_st = exp_st[cyc];
                chk("wr_en", {31'd0, bus.wr_en}, {31'd0, exp_we.exists(cyc)});
                if (exp_we.exists(cyc)) begin
                    chk("wr_addr", {26'd0, bus.wr_addr}, {26'd0, exp_wa[cyc]});
                    chk("wr_data", bus.wr_data, exp_wd[cyc]);
                    model_rf[exp_wa[cyc]] = exp_wd[cyc];
                end
                chk("done", {31'd0, bus.done}, {31'd0, exp_done.exists(cyc)});
                chk("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, !busy.exists(cyc)});
                chk("rd_a_addr", {26'd0, bus.rd_a_addr}, exp_ra.exists(cyc) ? {26'd0, exp_ra[cyc]} : 32'd0);
                chk("alu_a", bus.alu_a, exp_aa.exists(cyc) ? exp_aa[cyc] : 32'd0);
                chk("status", {29'd0, bus.st_overflow, bus.st_cout, bus.st_all_zero}, {29'd0, cur_st});
                if (bus.done) last_done = cyc;
            end
        end
    end

    // Expected behaviour of one command accepted in cycle c
    task automatic plan(input int c, input logic [3:0] op, input logic sg, input logic [4:0] sh,
                        input int va, input int vb, input int vd, input int len);
        int L;
        logic [34:0] r;
        logic ov, co, z;
        L = (len > VLEN) ? VLEN : len;
        ov = 1'b0; co = 1'b0; z = 1'b1;
        for (int i = 0; i < L; i++) begin
            r = alu_fn(op, sg, sh, model_rf[va*VLEN+i], model_rf[vb*VLEN+i]);
            exp_ra[c+1+i] = (RW+EW)'(va*VLEN+i);
            exp_aa[c+1+i] = model_rf[va*VLEN+i];
            exp_we[c+2+i] = 1'b1;
            exp_wa[c+2+i] = (RW+EW)'(vd*VLEN+i);
            exp_wd[c+2+i] = r[31:0];
            z  = z & r[34];
            ov = ov | r[33];
            co = co | r[32];
        end
        for (int k = c + 1; k <= c + L + 1; k++) busy[k] = 1'b1;
        exp_done[c+L+1] = 1'b1;
`ifdef VSEQ_FLAG_ACCUM_EN
        exp_st[c+L+1] = {ov, co, z};
`else
        exp_st[c+L+1] = 3'b000;
`endif
    endtask

    task automatic issue(input logic [3:0] op, input logic sg, input logic [4:0] sh, input int va,
                         input int vb, input int vd, input int len, input bit hold, output int c_acc);
        int n;
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_sign = sg; bus.cmd_shamt = sh;
        bus.cmd_va = RW'(va); bus.cmd_vb = RW'(vb); bus.cmd_vd = RW'(vd);
        bus.cmd_len = (EW+1)'(len); bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        c_acc = cyc;
        if (!bus.cmd_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
        end else begin
            plan(cyc, op, sg, sh, va, vb, vd, len);
            if (!hold) begin
                @(posedge clk);
                #1 bus.cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic load(input int addr, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = (RW+EW)'(addr); pl_data = d; model_rf[addr] = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    initial begin
        int c, c2;
        bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_sign = 1'b0; bus.cmd_shamt = 5'd0;
        bus.cmd_va = '0; bus.cmd_vb = '0; bus.cmd_vd = '0; bus.cmd_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_wr_addr", {26'd0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_status", {29'd0, bus.st_overflow, bus.st_cout, bus.st_all_zero}, 32'd0);
        chk("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
        chk("rst_rd_b_addr", {26'd0, bus.rd_b_addr}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        for (int k = 0; k < NE; k++) begin
            case (k / VLEN)
                0, 4:    load(k, 32'(k % VLEN));
                1:       load(k, 32'd5);
                2:       load(k, 32'd7);
                default: load(k, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
            endcase
        end

        // ADD 5+7 over a full register, cmd_valid held through part of the busy window
        issue(4'd0, 1'b0, 5'd0, 1, 2, 3, 8, 1'b1, c);
        repeat (3) @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("add_done_cycle", 32'(last_done - c), 32'd9);
        for (int k = 0; k < VLEN; k++) chk("add_model", model_rf[3*VLEN+k], 32'd12);
        chk("add_st_all_zero", {31'd0, bus.st_all_zero}, 32'd0);
        chk("add_st_overflow", {31'd0, bus.st_overflow}, 32'd0);

        // Signed SUB overflow on one element
        load(5*VLEN, 32'h8000_0000);
        load(6*VLEN, 32'd1);
        issue(4'd1, 1'b1, 5'd0, 5, 6, 7, 1, 1'b0, c);
        repeat (4) @(negedge clk);
        chk("sub_done_cycle", 32'(last_done - c), 32'd2);
        chk("sub_result", rf[7*VLEN], 32'h7FFF_FFFF);
`ifdef VSEQ_FLAG_ACCUM_EN
        chk("sub_st_overflow", {31'd0, bus.st_overflow}, 32'd1);
`else
        chk("sub_st_overflow", {31'd0, bus.st_overflow}, 32'd0);
`endif

        // In-place ADD: reg4 = reg4 + reg0 over four elements
        issue(4'd0, 1'b0, 5'd0, 4, 0, 4, 4, 1'b0, c);
        repeat (7) @(negedge clk);
        for (int k = 0; k < VLEN; k++) chk("inplace", rf[4*VLEN+k], (k < 4) ? 32'(2*k) : 32'(k));

        // Empty command with cmd_valid still high in the busy cycle
        issue(4'd2, 1'b0, 5'd0, 1, 2, 3, 0, 1'b1, c);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("len0_done_cycle", 32'(last_done - c), 32'd1);
`ifdef VSEQ_FLAG_ACCUM_EN
        chk("len0_st_all_zero", {31'd0, bus.st_all_zero}, 32'd1);
`else
        chk("len0_st_all_zero", {31'd0, bus.st_all_zero}, 32'd0);
`endif

        // Back-to-back pair with cmd_valid held
        issue(4'd4, 1'b0, 5'd0, 3, 1, 5, 2, 1'b1, c);
        issue(4'd3, 1'b0, 5'd0, 2, 3, 6, 2, 1'b1, c2);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b_second_accept", 32'(c2 - c), 32'd4);
        chk("b2b_second_done", 32'(last_done - c), 32'd7);

        // Reset in cycle 3 of a full-length command
        issue(4'd0, 1'b0, 5'd0, 1, 2, 6, 8, 1'b0, c);
        while (cyc < c + 2) @(negedge clk);
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        exp_we.delete(); exp_wa.delete(); exp_wd.delete(); exp_done.delete();
        busy.delete(); exp_ra.delete(); exp_aa.delete(); exp_st.delete();
        cur_st = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("mid_rst_elem0", rf[6*VLEN], 32'd12);

        // Random commands, including over-long lengths and held valid
        for (int t = 0; t < 40; t++) begin
            bit hold;
            hold = $urandom_range(0, 1) == 1;
            issue(4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, NVREG-1), $urandom_range(0, NVREG-1), $urandom_range(0, NVREG-1),
                  $urandom_range(0, 12), hold, c);
            if (!hold || $urandom_range(0, 2) == 0) begin
                if (hold) begin
                    @(negedge clk);
                    bus.cmd_valid = 1'b0;
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < NE; k++) chk("final_rf", rf[k], model_rf[k]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
